// File: rtl/movo_pkg.sv
// ============================================================================
// movo_pkg : word, frame and tick constants shared by the MOVO link blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package movo_pkg;

    localparam int MOVO_WORD_W      = 16;
    localparam int MOVO_FRAME_TICKS = 32;
    localparam int MOVO_LOAD_TICK   = 31;
    localparam int MOVO_COMMIT_TICK = 15;

    typedef logic signed [MOVO_WORD_W-1:0] movo_word_t;
    typedef logic signed [MOVO_WORD_W:0]   movo_wide_t;

endpackage

`default_nettype wire

// File: rtl/movo_slew_sat.sv
// ============================================================================
// movo_slew_sat : saturates a command into a target and slews value toward it
// Rev 1.0
// ============================================================================
`default_nettype none

module movo_slew_sat
    import movo_pkg::*;
#(
    parameter movo_word_t MAX_STEP  = 16'sd512,
    parameter movo_word_t POS_LIMIT = 16'sd30000,
    parameter movo_word_t NEG_LIMIT = -16'sd30000
) (
    input  logic                          pend_valid,
    input  logic signed [MOVO_WORD_W-1:0] cmd,
    input  logic signed [MOVO_WORD_W-1:0] target,
    input  logic signed [MOVO_WORD_W-1:0] value,
    output logic signed [MOVO_WORD_W-1:0] next_target,
    output logic signed [MOVO_WORD_W-1:0] next_value,
    output logic                          clip
);

    localparam movo_wide_t C_MAX_W = {1'b0, MAX_STEP};

    movo_word_t w_sat_cmd;
    movo_wide_t w_diff;
    movo_word_t w_step;

    always_comb begin
        w_sat_cmd = cmd;
        clip      = 1'b0;
        if (cmd > POS_LIMIT) begin
            w_sat_cmd = POS_LIMIT;
            clip      = 1'b1;
        end else if (cmd < NEG_LIMIT) begin
            w_sat_cmd = NEG_LIMIT;
            clip      = 1'b1;
        end

        next_target = pend_valid ? w_sat_cmd : target;

        // 17-bit difference: limits span more than a 16-bit signed range
        w_diff = {next_target[MOVO_WORD_W-1], next_target} - {value[MOVO_WORD_W-1], value};
        if (w_diff > C_MAX_W) begin
            w_step = MAX_STEP;
        end else if (w_diff < -C_MAX_W) begin
            w_step = -MAX_STEP;
        end else begin
            w_step = w_diff[MOVO_WORD_W-1:0];
        end

        next_value = value + w_step;
    end

endmodule

`default_nettype wire

// File: rtl/movo_cmd_scheduler.sv
// ============================================================================
// movo_cmd_scheduler : command intake, mid-frame commit and bit-rate strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module movo_cmd_scheduler
    import movo_pkg::*;
#(
    parameter int         CLK_DIV   = 50,
    parameter movo_word_t MAX_STEP  = 16'sd512,
    parameter movo_word_t POS_LIMIT = 16'sd30000,
    parameter movo_word_t NEG_LIMIT = -16'sd30000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic signed [MOVO_WORD_W-1:0] cmd_A,
    input  logic signed [MOVO_WORD_W-1:0] cmd_B,
    input  logic                          clear_flags,
    output logic                          enable_out,
    output logic signed [MOVO_WORD_W-1:0] value_A,
    output logic signed [MOVO_WORD_W-1:0] value_B,
    output logic                          frame_start,
    output logic                          sat_A,
    output logic                          sat_B,
    output logic                          underrun
);

    localparam int                C_TICK_W      = $clog2(MOVO_FRAME_TICKS);
    localparam logic [15:0]       C_DIV_LAST    = 16'(CLK_DIV - 1);
    localparam logic [C_TICK_W-1:0] C_COMMIT_TICK = C_TICK_W'(MOVO_COMMIT_TICK);
    localparam logic [C_TICK_W-1:0] C_LOAD_TICK   = C_TICK_W'(MOVO_LOAD_TICK);

    logic [15:0]         r_div_cnt;
    logic [C_TICK_W-1:0] r_tick_cnt;
    logic                r_pend_full;
    logic                r_ready;
    movo_word_t          r_pend_a, r_pend_b;
    movo_word_t          r_target_a, r_target_b;
    movo_word_t          r_value_a, r_value_b;
    logic                r_sat_a, r_sat_b;
    logic                r_underrun;

    logic                w_enable;
    logic                w_commit;
    logic                w_accept;
    logic                w_pend_full_nxt;
    movo_word_t          w_tgt_a, w_tgt_b;
    movo_word_t          w_val_a, w_val_b;
    logic                w_clip_a, w_clip_b;

    assign w_enable = run && (r_div_cnt == C_DIV_LAST);
    assign w_commit = w_enable && (r_tick_cnt == C_COMMIT_TICK);
    assign w_accept = cmd_valid && r_ready;

    // A commit only empties a full slot, and a full slot never accepts
    always_comb begin
        w_pend_full_nxt = r_pend_full;
        if (w_accept) begin
            w_pend_full_nxt = 1'b1;
        end else if (w_commit) begin
            w_pend_full_nxt = 1'b0;
        end
    end

    movo_slew_sat #(
        .MAX_STEP  (MAX_STEP),
        .POS_LIMIT (POS_LIMIT),
        .NEG_LIMIT (NEG_LIMIT)
    ) u_slew_a (
        .pend_valid  (r_pend_full),
        .cmd         (r_pend_a),
        .target      (r_target_a),
        .value       (r_value_a),
        .next_target (w_tgt_a),
        .next_value  (w_val_a),
        .clip        (w_clip_a)
    );

    movo_slew_sat #(
        .MAX_STEP  (MAX_STEP),
        .POS_LIMIT (POS_LIMIT),
        .NEG_LIMIT (NEG_LIMIT)
    ) u_slew_b (
        .pend_valid  (r_pend_full),
        .cmd         (r_pend_b),
        .target      (r_target_b),
        .value       (r_value_b),
        .next_target (w_tgt_b),
        .next_value  (w_val_b),
        .clip        (w_clip_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_pend_full <= 1'b0;
            r_ready     <= 1'b0;
            r_pend_a    <= '0;
            r_pend_b    <= '0;
            r_target_a  <= '0;
            r_target_b  <= '0;
            r_value_a   <= '0;
            r_value_b   <= '0;
            r_sat_a     <= 1'b0;
            r_sat_b     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (!run || w_enable) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            if (w_enable) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_accept) begin
                r_pend_a <= cmd_A;
                r_pend_b <= cmd_B;
            end
            r_pend_full <= w_pend_full_nxt;
            r_ready     <= !w_pend_full_nxt;

            if (w_commit) begin
                r_target_a <= w_tgt_a;
                r_target_b <= w_tgt_b;
                r_value_a  <= w_val_a;
                r_value_b  <= w_val_b;
                if (r_pend_full) begin
                    r_sat_a <= w_clip_a;
                    r_sat_b <= w_clip_b;
                end
            end

            if (w_commit && !r_pend_full) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign cmd_ready   = r_ready;
    assign enable_out  = w_enable;
    assign frame_start = w_enable && (r_tick_cnt == C_LOAD_TICK);
    assign value_A     = r_value_a;
    assign value_B     = r_value_b;
    assign sat_A       = r_sat_a;
    assign sat_B       = r_sat_b;
    assign underrun    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_movo_cmd_scheduler.sv
// ============================================================================
// tb_movo_cmd_scheduler : two schedulers (step 512 / step 32767) against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_movo_cmd_scheduler;

    localparam int D = 4;

    typedef struct {
        int ta;
        int tb;
        bit sa;
        bit sb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic clear_flags;
    logic [1:0] cmd_valid;
    logic [1:0] cmd_ready, enable_out, frame_start, sat_a, sat_b, underrun;
    logic signed [15:0] cmd_a [2];
    logic signed [15:0] cmd_b [2];
    logic signed [15:0] value_a [2];
    logic signed [15:0] value_b [2];

    int n_vec = 0;
    int n_err = 0;
    int n_commit = 0;

    // reference model state, advanced on every rising edge
    int   m_div, m_tick;
    int   m_va [2], m_vb [2], m_ta [2], m_tb [2];
    bit   m_sa [2], m_sb [2], m_ur [2], m_rdy [2];
    exp_t q0 [$];
    exp_t q1 [$];

    movo_cmd_scheduler #(.CLK_DIV(D), .MAX_STEP(16'sd512)) dut_s (
        .clk(clk), .rst(rst), .run(run),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_A(cmd_a[0]), .cmd_B(cmd_b[0]), .clear_flags(clear_flags),
        .enable_out(enable_out[0]), .value_A(value_a[0]), .value_B(value_b[0]),
        .frame_start(frame_start[0]), .sat_A(sat_a[0]), .sat_B(sat_b[0]),
        .underrun(underrun[0])
    );

    movo_cmd_scheduler #(.CLK_DIV(D), .MAX_STEP(16'sd32767)) dut_w (
        .clk(clk), .rst(rst), .run(run),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_A(cmd_a[1]), .cmd_B(cmd_b[1]), .clear_flags(clear_flags),
        .enable_out(enable_out[1]), .value_A(value_a[1]), .value_B(value_b[1]),
        .frame_start(frame_start[1]), .sat_A(sat_a[1]), .sat_B(sat_b[1]),
        .underrun(underrun[1])
    );

    always #5 clk = ~clk;

    function automatic int satv(input int x);
        if (x > 30000) return 30000;
        if (x < -30000) return -30000;
        return x;
    endfunction

    function automatic bit clipf(input int x);
        return (x > 30000) || (x < -30000);
    endfunction

    function automatic int slew(input int v, input int t, input int lim);
        int d;
        d = t - v;
        if (d > lim) d = lim;
        if (d < -lim) d = -lim;
        return v + d;
    endfunction

    function automatic bit next_is_commit();
        return run && (m_div == D - 1) && (m_tick == 15);
    endfunction

    task automatic model_edge(input int i, input bit com);
        exp_t e;
        bit   old_rdy;
        bit   set_ur;
        int   sz;
        old_rdy = m_rdy[i];
        set_ur  = 1'b0;
        if (com) begin
            sz = (i == 0) ? q0.size() : q1.size();
            if (sz > 0) begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                m_ta[i] = e.ta; m_tb[i] = e.tb; m_sa[i] = e.sa; m_sb[i] = e.sb;
            end else begin
                set_ur = 1'b1;
            end
            m_va[i] = slew(m_va[i], m_ta[i], (i == 0) ? 512 : 32767);
            m_vb[i] = slew(m_vb[i], m_tb[i], (i == 0) ? 512 : 32767);
        end
        if (set_ur) m_ur[i] = 1'b1;
        else if (clear_flags) m_ur[i] = 1'b0;
        if (cmd_valid[i] && old_rdy) begin
            e.ta = satv(cmd_a[i]); e.tb = satv(cmd_b[i]);
            e.sa = clipf(cmd_a[i]); e.sb = clipf(cmd_b[i]);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        m_rdy[i] = (((i == 0) ? q0.size() : q1.size()) == 0);
    endtask

    // scoreboard monitor: update model at the edge, compare 1 time unit later
    initial begin
        bit en, com, exp_en;
        m_div = 0; m_tick = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_div = 0; m_tick = 0;
                q0.delete(); q1.delete();
                for (int i = 0; i < 2; i++) begin
                    m_va[i] = 0; m_vb[i] = 0; m_ta[i] = 0; m_tb[i] = 0;
                    m_sa[i] = 0; m_sb[i] = 0; m_ur[i] = 0; m_rdy[i] = 0;
                end
            end else begin
                en  = run && (m_div == D - 1);
                com = en && (m_tick == 15);
                if (!run || en) m_div = 0;
                else            m_div = m_div + 1;
                if (en) m_tick = (m_tick + 1) % 32;
                if (com) n_commit++;
                for (int i = 0; i < 2; i++) model_edge(i, com);
            end
            #1;
            exp_en = rst && run && (m_div == D - 1);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (enable_out[i] !== exp_en) begin
                    n_err++; $display("FAIL mon_enable[%0d] t=%0t got %b exp %b", i, $time, enable_out[i], exp_en);
                end
                n_vec++;
                if (frame_start[i] !== (exp_en && m_tick == 31)) begin
                    n_err++; $display("FAIL mon_frame_start[%0d] t=%0t got %b exp %b", i, $time, frame_start[i], exp_en && m_tick == 31);
                end
                n_vec++;
                if (cmd_ready[i] !== m_rdy[i]) begin
                    n_err++; $display("FAIL mon_cmd_ready[%0d] t=%0t got %b exp %b", i, $time, cmd_ready[i], m_rdy[i]);
                end
                n_vec++;
                if (value_a[i] !== 16'(m_va[i]) || value_b[i] !== 16'(m_vb[i])) begin
                    n_err++; $display("FAIL mon_values[%0d] t=%0t got %0d/%0d exp %0d/%0d", i, $time, value_a[i], value_b[i], m_va[i], m_vb[i]);
                end
                n_vec++;
                if (sat_a[i] !== m_sa[i] || sat_b[i] !== m_sb[i] || underrun[i] !== m_ur[i]) begin
                    n_err++; $display("FAIL mon_flags[%0d] t=%0t got sat %b%b ur %b exp sat %b%b ur %b", i, $time, sat_a[i], sat_b[i], underrun[i], m_sa[i], m_sb[i], m_ur[i]);
                end
            end
        end
    end

    task automatic wait_commit();
        int start, k;
        start = n_commit;
        k = 0;
        while (n_commit == start && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (n_commit == start) begin
            n_err++; $display("FAIL wait_commit timeout got %0d commits exp %0d", n_commit, start + 1);
        end
    endtask

    task automatic send(input int i, input int a, input int b);
        int k;
        k = 0;
        @(negedge clk);
        while ((!cmd_ready[i] || next_is_commit()) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 400) begin
            n_err++; $display("FAIL send_ready_timeout[%0d] got %b exp 1", i, cmd_ready[i]);
        end
        cmd_valid[i] = 1'b1;
        cmd_a[i] = 16'(a);
        cmd_b[i] = 16'(b);
        @(negedge clk);
        cmd_valid[i] = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        while (next_is_commit()) @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; clear_flags = 1'b0; cmd_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin cmd_a[i] = '0; cmd_b[i] = '0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({cmd_ready[i], enable_out[i], frame_start[i], sat_a[i], sat_b[i], underrun[i], value_a[i], value_b[i]} !== 38'd0) begin
                n_err++; $display("FAIL reset_outputs[%0d] got rdy %b en %b val %0d/%0d exp all 0", i, cmd_ready[i], enable_out[i], value_a[i], value_b[i]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (cmd_ready[i] !== 1'b1) begin
                n_err++; $display("FAIL reset_release_ready[%0d] got %b exp 1", i, cmd_ready[i]);
            end
        end
    endtask

    task automatic test_divider();
        int ne, nf;
        ne = 0; nf = 0;
        repeat (128) begin
            @(negedge clk);
            ne += int'(enable_out[0]);
            nf += int'(frame_start[0]);
        end
        n_vec++;
        if (ne != 32) begin n_err++; $display("FAIL divider_enables got %0d exp 32", ne); end
        n_vec++;
        if (nf != 1) begin n_err++; $display("FAIL divider_frames got %0d exp 1", nf); end
    endtask

    task automatic test_slew();
        wait_commit();
        send(0, 1000, -200);
        pulse_clear();
        wait_commit();
        n_vec++;
        if (value_a[0] !== 16'sd512 || value_b[0] !== -16'sd200) begin
            n_err++; $display("FAIL slew_first got %0d/%0d exp 512/-200", value_a[0], value_b[0]);
        end
        n_vec++;
        if (underrun[0] !== 1'b0) begin n_err++; $display("FAIL slew_no_underrun got %b exp 0", underrun[0]); end
        wait_commit();
        n_vec++;
        if (value_a[0] !== 16'sd1000 || underrun[0] !== 1'b1) begin
            n_err++; $display("FAIL slew_second got %0d ur %b exp 1000 ur 1", value_a[0], underrun[0]);
        end
        pulse_clear();
        n_vec++;
        if (underrun[0] !== 1'b0) begin n_err++; $display("FAIL clear_underrun got %b exp 0", underrun[0]); end
    endtask

    task automatic test_saturation();
        wait_commit();
        send(1, 32000, -32768);
        wait_commit();
        n_vec++;
        if (value_a[1] !== 16'sd30000 || value_b[1] !== -16'sd30000 || sat_a[1] !== 1'b1 || sat_b[1] !== 1'b1) begin
            n_err++; $display("FAIL sat_clip got %0d/%0d sat %b%b exp 30000/-30000 sat 11", value_a[1], value_b[1], sat_a[1], sat_b[1]);
        end
        send(1, 5, -30000);
        wait_commit();
        n_vec++;
        if (value_a[1] !== 16'sd5 || sat_a[1] !== 1'b0 || sat_b[1] !== 1'b0) begin
            n_err++; $display("FAIL sat_release got %0d sat %b%b exp 5 sat 00", value_a[1], sat_a[1], sat_b[1]);
        end
    endtask

    task automatic test_no_wrap();
        send(1, -30000, 0);
        wait_commit();
        n_vec++;
        if (value_a[1] !== -16'sd30000 || value_b[1] !== 16'sd0) begin
            n_err++; $display("FAIL wrap_setup got %0d/%0d exp -30000/0", value_a[1], value_b[1]);
        end
        send(1, 30000, 0);
        wait_commit();
        n_vec++;
        if (value_a[1] !== 16'sd2767) begin n_err++; $display("FAIL wrap_step got %0d exp 2767", value_a[1]); end
        wait_commit();
        n_vec++;
        if (value_a[1] !== 16'sd30000) begin n_err++; $display("FAIL wrap_final got %0d exp 30000", value_a[1]); end
    endtask

    task automatic test_back_to_back();
        int k;
        wait_commit();
        send(0, 3000, 400);
        n_vec++;
        if (cmd_ready[0] !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %b exp 0", cmd_ready[0]); end
        cmd_valid[0] = 1'b1;
        cmd_a[0] = -16'sd700;
        cmd_b[0] = -16'sd5000;
        k = 0;
        while (!cmd_ready[0] && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 400) begin n_err++; $display("FAIL b2b_ready_timeout got %b exp 1", cmd_ready[0]); end
        n_vec++;
        if (value_a[0] !== 16'sd1512 || value_b[0] !== 16'sd312) begin
            n_err++; $display("FAIL b2b_first got %0d/%0d exp 1512/312", value_a[0], value_b[0]);
        end
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        wait_commit();
        n_vec++;
        if (value_a[0] !== 16'sd1000 || value_b[0] !== -16'sd200) begin
            n_err++; $display("FAIL b2b_second got %0d/%0d exp 1000/-200", value_a[0], value_b[0]);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        k = 0;
        while (!next_is_commit() && k < 400) begin
            @(negedge clk);
            k++;
        end
        cmd_valid[0] = 1'b1;
        cmd_a[0] = '0;
        cmd_b[0] = '0;
        clear_flags = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        clear_flags = 1'b0;
        n_vec++;
        if (underrun[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
            n_err++; $display("FAIL simul_set_wins got ur %b rdy %b exp ur 1 rdy 0", underrun[0], cmd_ready[0]);
        end
        n_vec++;
        if (value_a[0] !== 16'sd488 || value_b[0] !== -16'sd712) begin
            n_err++; $display("FAIL simul_old_target got %0d/%0d exp 488/-712", value_a[0], value_b[0]);
        end
        wait_commit();
        n_vec++;
        if (value_a[0] !== 16'sd0 || value_b[0] !== -16'sd200) begin
            n_err++; $display("FAIL simul_applied got %0d/%0d exp 0/-200", value_a[0], value_b[0]);
        end
    endtask

    task automatic test_run_pause();
        int k, ne;
        k = 0;
        while (m_tick != 8 && k < 400) begin
            @(negedge clk);
            k++;
        end
        run = 1'b0;
        ne = 0;
        repeat (40) begin
            @(negedge clk);
            ne += int'(enable_out[0]) + int'(enable_out[1]);
        end
        n_vec++;
        if (ne != 0) begin n_err++; $display("FAIL pause_enables got %0d exp 0", ne); end
        n_vec++;
        if (value_a[1] !== 16'sd30000) begin n_err++; $display("FAIL pause_hold got %0d exp 30000", value_a[1]); end
        run = 1'b1;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, n;
        k = 0;
        while (m_tick != 20 && k < 400) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({cmd_ready[i], enable_out[i], frame_start[i], sat_a[i], sat_b[i], underrun[i], value_a[i], value_b[i]} !== 38'd0) begin
                n_err++; $display("FAIL midreset_outputs[%0d] got rdy %b ur %b val %0d/%0d exp all 0", i, cmd_ready[i], underrun[i], value_a[i], value_b[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // enable seen after D-1 edges is consumed on the D-th edge
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable_out[0] && n < 100);
        n_vec++;
        if (n != D - 1) begin n_err++; $display("FAIL midreset_first_enable got %0d exp %0d", n, D - 1); end
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start[0] && n < 1000);
        n_vec++;
        if (n != 32 * D - 1) begin n_err++; $display("FAIL midreset_first_frame got %0d exp %0d", n, 32 * D - 1); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_slew();
        test_saturation();
        test_no_wrap();
        test_back_to_back();
        test_simultaneous();
        test_run_pause();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
